// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute path: ALU control codes,
// shifter op kinds and execute FSM states.
package alu_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SHAMT_W = $clog2(ALU_XLEN);

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_AND  = 5'b00001,
        ALU_OR   = 5'b00010,
        ALU_XOR  = 5'b00011,
        ALU_SLL  = 5'b00100,
        ALU_SRL  = 5'b00101,
        ALU_SRA  = 5'b00110,
        ALU_SUB  = 5'b10000,
        ALU_SLT  = 5'b10111,
        ALU_SLTU = 5'b11000
    } alu_op_e;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } exec_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: load latches source, amount and kind; done is
// high on the cycle whose shift produces the final value on result.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int W  = ALU_XLEN,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [1:0]    kind,
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] shamt,
    output logic          done,
    output logic [W-1:0]  result
);

    logic [W-1:0]  work_r;
    logic [SW-1:0] cnt_r;
    shift_kind_e   kind_r;
    logic [W-1:0]  shift_s;

    // Single-bit shift of the working register for the latched kind.
    always_comb begin
        shift_s = work_r;
        case (kind_r)
            SHIFT_SLL: shift_s = {work_r[W-2:0], 1'b0};
            SHIFT_SRL: shift_s = {1'b0, work_r[W-1:1]};
            SHIFT_SRA: shift_s = {work_r[W-1], work_r[W-1:1]};
            default:   shift_s = work_r;
        endcase
    end

    // Working register and remaining-count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= {W{1'b0}};
            cnt_r  <= {SW{1'b0}};
            kind_r <= SHIFT_SLL;
        end else if (load) begin
            work_r <= data;
            cnt_r  <= shamt;
            kind_r <= shift_kind_e'(kind);
        end else if (cnt_r != {SW{1'b0}}) begin
            work_r <= shift_s;
            cnt_r  <= cnt_r - SW'(1);
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    assign done   = (cnt_r == SW'(1));
    assign result = shift_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle logic/arith/compare datapath, serial
// shifter for SLL/SRL/SRA, and a registered valid/ready result stage.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    exec_state_e       state_r;
    exec_state_e       state_nxt_s;
    logic              o_valid_r;
    logic [XLEN-1:0]   o_result_r;
    logic              o_zero_r;
    logic              ready_s;
    logic              accept_s;
    logic              is_shift_s;
    logic [1:0]        shift_kind_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic              start_shift_s;
    logic [XLEN-1:0]   alu_result_s;
    logic              shift_done_s;
    logic [XLEN-1:0]   shift_result_s;

    assign shamt_s       = i_operand_b[SHAMT_W-1:0];
    assign ready_s       = (state_r == ST_IDLE) && (!o_valid_r || i_ready);
    assign accept_s      = i_valid && ready_s;
    assign start_shift_s = accept_s && is_shift_s && (shamt_s != {SHAMT_W{1'b0}});

    // Single-cycle result; a shift by zero simply passes operand A through.
    always_comb begin
        alu_result_s = i_operand_a + i_operand_b;
        case (i_alu_control)
            ALU_ADD:  alu_result_s = i_operand_a + i_operand_b;
            ALU_SUB:  alu_result_s = i_operand_a - i_operand_b;
            ALU_AND:  alu_result_s = i_operand_a & i_operand_b;
            ALU_OR:   alu_result_s = i_operand_a | i_operand_b;
            ALU_XOR:  alu_result_s = i_operand_a ^ i_operand_b;
            ALU_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
            ALU_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (i_operand_a < i_operand_b)};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_result_s = i_operand_a;
            default:  alu_result_s = i_operand_a + i_operand_b;
        endcase
    end

    // Shift classification of the incoming control code.
    always_comb begin
        is_shift_s   = 1'b0;
        shift_kind_s = SHIFT_SLL;
        case (i_alu_control)
            ALU_SLL: begin is_shift_s = 1'b1; shift_kind_s = SHIFT_SLL; end
            ALU_SRL: begin is_shift_s = 1'b1; shift_kind_s = SHIFT_SRL; end
            ALU_SRA: begin is_shift_s = 1'b1; shift_kind_s = SHIFT_SRA; end
            default: begin is_shift_s = 1'b0; shift_kind_s = SHIFT_SLL; end
        endcase
    end

    alu_serial_shifter #(
        .W  (XLEN),
        .SW (SHAMT_W)
    ) u_shifter (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (start_shift_s),
        .kind   (shift_kind_s),
        .data   (i_operand_a),
        .shamt  (shamt_s),
        .done   (shift_done_s),
        .result (shift_result_s)
    );

    // Execute FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Execute FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_shift_s) state_nxt_s = ST_SHIFT;
                else               state_nxt_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (shift_done_s) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_SHIFT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result register; holds while a valid result is stalled downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_r  <= 1'b0;
            o_result_r <= {XLEN{1'b0}};
            o_zero_r   <= 1'b1;
        end else if (start_shift_s) begin
            o_valid_r  <= 1'b0;
        end else if (accept_s) begin
            o_valid_r  <= 1'b1;
            o_result_r <= alu_result_s;
            o_zero_r   <= (alu_result_s == {XLEN{1'b0}});
        end else if ((state_r == ST_SHIFT) && shift_done_s) begin
            o_valid_r  <= 1'b1;
            o_result_r <= shift_result_s;
            o_zero_r   <= (shift_result_s == {XLEN{1'b0}});
        end else if (o_valid_r && i_ready) begin
            o_valid_r  <= 1'b0;
        end else begin
            o_valid_r  <= o_valid_r;
        end
    end

    assign o_ready  = ready_s;
    assign o_valid  = o_valid_r;
    assign o_result = o_result_r;
    assign o_zero   = o_zero_r;
    assign o_busy   = (state_r == ST_SHIFT);

endmodule
